// File: rtl/vec_lane_sequencer_pkg.sv
// Shared definitions for the vector lane sequencer: ALU encodings, lane count, FSM states.
// VEC_SEQ_MUL_EN adds the multiplier wait state.
package vec_pkg;

    localparam int unsigned VEC_LANES = 5;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;
    localparam logic [2:0] AluMul = 3'b110;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
`ifdef VEC_SEQ_MUL_EN
        StMulWait = 2'd2,
`endif
        StFinish  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/vec_lane_sequencer_if.sv
// Instruction, operand-read, multiplier and writeback signals of the lane sequencer.
// master = decode/regfile/multiplier side, slave = sequencer.
interface vec_lane_sequencer_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic             ready;
    logic [2:0]       vl;
    logic [2:0]       alu_ctrl;
    logic [2:0]       lane_idx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_result;
    logic             wr_en;
    logic [2:0]       wr_lane;
    logic [WIDTH-1:0] wr_data;
    logic             done;
    logic [1:0]       vflags;

    modport master (
        output start, vl, alu_ctrl, op_a, op_b, mul_done, mul_result,
        input  ready, lane_idx, mul_start, wr_en, wr_lane, wr_data, done, vflags
    );

    modport slave (
        input  start, vl, alu_ctrl, op_a, op_b, mul_done, mul_result,
        output ready, lane_idx, mul_start, wr_en, wr_lane, wr_data, done, vflags
    );
endinterface

// File: rtl/vec_lane_alu.sv
// Combinational single-lane add/sub/and/or/xor unit; any other code yields 0.
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] b_eff;

    always_comb begin
        // ctrl[0] selects subtract: a + ~b + 1
        b_eff = ctrl[0] ? ~b : b;
        case (ctrl)
            AluAdd, AluSub: result = a + b_eff + WIDTH'(ctrl[0]);
            AluAnd:         result = a & b;
            AluOr:          result = a | b;
            AluXor:         result = a ^ b;
            default:        result = '0;
        endcase
    end
endmodule

// File: rtl/vec_lane_sequencer.sv
// Time-shared single-lane vector sequencer: one lane read, computed and written per cycle.
// VEC_SEQ_MUL_EN routes code 110 through the external multiplier handshake.
module vec_lane_sequencer
    import vec_pkg::*;
#(
    parameter int unsigned LANES = VEC_LANES,
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    vec_lane_sequencer_if.slave  bus
);
    seq_state_e       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       vl_q, vl_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             wr_en_q, wr_en_d;
    logic [2:0]       wr_lane_q, wr_lane_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             all_zero_q, all_zero_d;
    logic             any_neg_q, any_neg_d;

    logic [WIDTH-1:0] alu_result;
    logic [2:0]       vl_clamped;
    logic             last_lane;
    logic             is_mul;

    vec_lane_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .ctrl   (ctrl_q),
        .a      (bus.op_a),
        .b      (bus.op_b),
        .result (alu_result)
    );

    assign vl_clamped = (bus.vl > 3'(LANES)) ? 3'(LANES) : bus.vl;
    assign last_lane  = (cnt_q == vl_q - 3'd1);

`ifdef VEC_SEQ_MUL_EN
    assign is_mul = (ctrl_q == AluMul);
`else
    assign is_mul = 1'b0;
    logic unused_mul;
    assign unused_mul = ^{bus.mul_done, bus.mul_result};
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        vl_d          = vl_q;
        ctrl_d        = ctrl_q;
        wr_en_d       = 1'b0;
        wr_lane_d     = wr_lane_q;
        wr_data_d     = wr_data_q;
        all_zero_d    = all_zero_q;
        any_neg_d     = any_neg_q;
        bus.ready     = 1'b0;
        bus.mul_start = 1'b0;
        bus.done      = 1'b0;
        bus.lane_idx  = '0;

        if (wr_en_q) begin
            all_zero_d = all_zero_q & (wr_data_q == '0);
            any_neg_d  = any_neg_q | wr_data_q[WIDTH-1];
        end

        unique case (state_q)
            StIdle: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    vl_d       = vl_clamped;
                    ctrl_d     = bus.alu_ctrl;
                    cnt_d      = '0;
                    all_zero_d = 1'b1;
                    any_neg_d  = 1'b0;
                    state_d    = (vl_clamped == '0) ? StFinish : StIssue;
                end
            end
            StIssue: begin
                bus.lane_idx = cnt_q;
                if (is_mul) begin
`ifdef VEC_SEQ_MUL_EN
                    bus.mul_start = 1'b1;
                    state_d       = StMulWait;
`endif
                end else begin
                    wr_en_d   = 1'b1;
                    wr_lane_d = cnt_q;
                    wr_data_d = alu_result;
                    cnt_d     = cnt_q + 3'd1;
                    if (last_lane) state_d = StFinish;
                end
            end
`ifdef VEC_SEQ_MUL_EN
            StMulWait: begin
                bus.lane_idx = cnt_q;
                if (bus.mul_done) begin
                    wr_en_d   = 1'b1;
                    wr_lane_d = cnt_q;
                    wr_data_d = bus.mul_result;
                    cnt_d     = cnt_q + 3'd1;
                    state_d   = last_lane ? StFinish : StIssue;
                end
            end
`endif
            StFinish: begin
                // Hold done until the last write has landed in the flags.
                if (!wr_en_q) begin
                    bus.done = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            vl_q       <= '0;
            ctrl_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_lane_q  <= '0;
            wr_data_q  <= '0;
            all_zero_q <= 1'b1;
            any_neg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vl_q       <= vl_d;
            ctrl_q     <= ctrl_d;
            wr_en_q    <= wr_en_d;
            wr_lane_q  <= wr_lane_d;
            wr_data_q  <= wr_data_d;
            all_zero_q <= all_zero_d;
            any_neg_q  <= any_neg_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_lane = wr_lane_q;
    assign bus.wr_data = wr_data_q;
    assign bus.vflags  = {any_neg_q, all_zero_q};
endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Directed bench for vec_lane_sequencer; expectations follow VEC_SEQ_MUL_EN when defined.
module tb_vec_lane_sequencer;
    import vec_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vec_lane_sequencer_if #(.WIDTH(32)) bus ();

    vec_lane_sequencer #(
        .LANES (5),
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file model: op_a = a_base + a_inc * lane, op_b constant
    logic [31:0] a_base, a_inc, b_val;
    assign bus.op_a = a_base + a_inc * {29'd0, bus.lane_idx};
    assign bus.op_b = b_val;

    int n_assert = 0;
    int n_fail   = 0;

    int          nwr, nmul, done_cyc;
    logic [2:0]  lane_log [8];
    logic [31:0] data_log [8];
    int          cyc_log  [8];
    logic [1:0]  flags;
    logic        ready_busy, ready_after;

    // Multiplier model: done 3 cycles after mul_start, low 32 bits of the product
    initial begin
        int mdelay;
        mdelay         = 0;
        bus.mul_done   = 1'b0;
        bus.mul_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mdelay > 0) begin
                mdelay--;
                bus.mul_done = (mdelay == 0);
            end else begin
                bus.mul_done = 1'b0;
            end
            if (bus.mul_start) begin
                mdelay         = 3;
                bus.mul_result = bus.op_a * bus.op_b;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction; cycle 1 is the cycle after the accept edge
    task automatic run(input logic [2:0] ctrl, input logic [2:0] vl, input bit inject);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.alu_ctrl = ctrl;
        bus.vl       = vl;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        nwr         = 0;
        nmul        = 0;
        done_cyc    = -1;
        flags       = 'x;
        ready_busy  = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) ready_busy = bus.ready;
            if (bus.mul_start) nmul++;
            if (bus.wr_en && nwr < 8) begin
                lane_log[nwr] = bus.wr_lane;
                data_log[nwr] = bus.wr_data;
                cyc_log[nwr]  = c;
                nwr++;
            end
            if (inject && c == 2) begin
                bus.start = 1'b1;
                bus.vl    = 3'd1;
            end
            if (inject && c == 3) bus.start = 1'b0;
            if (bus.done) begin
                done_cyc = c;
                flags    = bus.vflags;
                break;
            end
        end
        @(negedge clk);
        ready_after = bus.ready;
    endtask

    initial begin
        logic [31:0] exp_x [5];
        exp_x = '{32'd2, 32'd1, 32'd0, 32'd7, 32'd6};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.vl       = '0;
        bus.alu_ctrl = '0;
        a_base       = '0;
        a_inc        = '0;
        b_val        = '0;
        #2 reset = 1'b0;
        #10;
        chk("rst_ready",     bus.ready,     1);
        chk("rst_lane_idx",  bus.lane_idx,  0);
        chk("rst_mul_start", bus.mul_start, 0);
        chk("rst_wr_en",     bus.wr_en,     0);
        chk("rst_done",      bus.done,      0);
        chk("rst_wr_lane",   bus.wr_lane,   0);
        chk("rst_wr_data",   bus.wr_data,   0);
        chk("rst_vflags",    bus.vflags,    2'b01);
        @(negedge clk);
        reset = 1'b1;

        // add vl=3: 11,12,13 in cycles 2..4, done in 5
        a_base = 1; a_inc = 1; b_val = 10;
        run(AluAdd, 3'd3, 1'b0);
        chk("add_nwr", nwr, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("add_lane%0d", i), lane_log[i], i);
            chk($sformatf("add_data%0d", i), data_log[i], 11 + i);
            chk($sformatf("add_cyc%0d", i),  cyc_log[i],  i + 2);
        end
        chk("add_done_cyc",    done_cyc,    5);
        chk("add_vflags",      flags,       2'b00);
        chk("add_ready_busy",  ready_busy,  0);
        chk("add_ready_after", ready_after, 1);

        // sub vl=5 of equal operands, with a start pulse mid-instruction
        a_base = 7; a_inc = 0; b_val = 7;
        run(AluSub, 3'd5, 1'b1);
        chk("sub0_nwr", nwr, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("sub0_lane%0d", i), lane_log[i], i);
            chk($sformatf("sub0_data%0d", i), data_log[i], 0);
        end
        chk("sub0_done_cyc",    done_cyc,    7);
        chk("sub0_vflags",      flags,       2'b01);
        chk("sub0_ready_after", ready_after, 1);

        // sub with negative result
        a_base = 3; a_inc = 0; b_val = 5;
        run(AluSub, 3'd1, 1'b0);
        chk("subn_nwr",      nwr,         1);
        chk("subn_data",     data_log[0], 32'hFFFF_FFFE);
        chk("subn_done_cyc", done_cyc,    3);
        chk("subn_vflags",   flags,       2'b10);

        // and / or
        a_base = 32'hFF00_FF00; a_inc = 0; b_val = 32'h0FF0_0FF0;
        run(AluAnd, 3'd2, 1'b0);
        chk("and_nwr",    nwr,         2);
        chk("and_data0",  data_log[0], 32'h0F00_0F00);
        chk("and_data1",  data_log[1], 32'h0F00_0F00);
        chk("and_vflags", flags,       2'b00);
        run(AluOr, 3'd1, 1'b0);
        chk("or_data",    data_log[0], 32'hFFF0_FFF0);
        chk("or_vflags",  flags,       2'b10);

        // xor vl=0: done in cycle 1, no writes
        run(AluXor, 3'd0, 1'b0);
        chk("xor0_nwr",        nwr,        0);
        chk("xor0_done_cyc",   done_cyc,   1);
        chk("xor0_vflags",     flags,      2'b01);
        chk("xor0_ready_busy", ready_busy, 0);

        // xor vl=7 clamps to 5 lanes
        a_base = 1; a_inc = 1; b_val = 3;
        run(AluXor, 3'd7, 1'b0);
        chk("xor7_nwr", nwr, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("xor7_lane%0d", i), lane_log[i], i);
            chk($sformatf("xor7_data%0d", i), data_log[i], exp_x[i]);
        end
        chk("xor7_done_cyc", done_cyc, 7);

        // mul vl=2: 0x80000000 * 2 -> 0
        a_base = 32'h8000_0000; a_inc = 0; b_val = 2;
        run(AluMul, 3'd2, 1'b0);
        chk("mul_nwr",   nwr,         2);
        chk("mul_data0", data_log[0], 0);
        chk("mul_data1", data_log[1], 0);
        chk("mul_vflags", flags,      2'b01);
`ifdef VEC_SEQ_MUL_EN
        chk("mul_nmul",     nmul,       2);
        chk("mul_cyc0",     cyc_log[0], 5);
        chk("mul_cyc1",     cyc_log[1], 9);
        chk("mul_done_cyc", done_cyc,   10);
`else
        chk("mul_nmul",     nmul,       0);
        chk("mul_cyc0",     cyc_log[0], 2);
        chk("mul_cyc1",     cyc_log[1], 3);
        chk("mul_done_cyc", done_cyc,   4);
`endif

        // mul vl=1: 3 * 5
        a_base = 3; a_inc = 0; b_val = 5;
        run(AluMul, 3'd1, 1'b0);
        chk("mul15_nwr", nwr, 1);
`ifdef VEC_SEQ_MUL_EN
        chk("mul15_data",     data_log[0], 15);
        chk("mul15_done_cyc", done_cyc,    6);
        chk("mul15_vflags",   flags,       2'b00);
`else
        chk("mul15_data",     data_log[0], 0);
        chk("mul15_done_cyc", done_cyc,    3);
        chk("mul15_vflags",   flags,       2'b01);
`endif

        // unused code 101 writes zeros
        a_base = 5; a_inc = 0; b_val = 3;
        run(3'b101, 3'd2, 1'b0);
        chk("c101_nwr",      nwr,         2);
        chk("c101_data0",    data_log[0], 0);
        chk("c101_data1",    data_log[1], 0);
        chk("c101_nmul",     nmul,        0);
        chk("c101_done_cyc", done_cyc,    4);
        chk("c101_vflags",   flags,       2'b01);

        // reset asserted while lane 2 is being read
        a_base = 1; a_inc = 1; b_val = 10;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.alu_ctrl = AluAdd;
        bus.vl       = 3'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstm_lane_before",  bus.lane_idx, 2);
        chk("rstm_flags_before", bus.vflags,   2'b00);
        reset = 1'b0;
        #1;
        chk("rstm_ready",    bus.ready,    1);
        chk("rstm_vflags",   bus.vflags,   2'b01);
        chk("rstm_wr_en",    bus.wr_en,    0);
        chk("rstm_lane_idx", bus.lane_idx, 0);
        nwr = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.wr_en || bus.done) nwr++;
            if (c == 0) reset = 1'b1;
        end
        chk("rstm_no_activity", nwr,       0);
        chk("rstm_ready_after", bus.ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_lane_sequencer.md
# vec_lane_sequencer

Multi-cycle sequencer for the vector datapath. It accepts one vector instruction (opcode plus vector length 0..5), steps lane by lane through the shared operand read port, and computes each lane with a single lane ALU. Multiplies go through an external multi-cycle multiplier handshake. Each lane result is written back through one write port, and aggregate vector flags are reported on completion. It sits between decode/control and the vector register file, replacing per-lane replicated ALUs with one time-shared lane.

## Interface
- `LANES`, default 5: number of vector lanes; also the maximum vector length.
- `WIDTH`, default 32: lane data width.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: instruction valid; accepted only when `ready`=1.
- `ready`, output, 1: sequencer idle and able to accept `start`.
- `vl`, input, 3: vector length, sampled at accept.
- `alu_ctrl`, input, 3: lane op, sampled at accept. Encodings: 000 add, 001 sub, 010 and, 011 or, 100 xor, 110 mul.
- `lane_idx`, output, 3: lane being read from the register file (asynchronous read).
- `op_a`, `op_b`, input, WIDTH: lane operands for `lane_idx`, same cycle.
- `mul_start`, output, 1: one-cycle pulse; the multiplier samples `op_a`/`op_b` in this cycle.
- `mul_done`, input, 1: multiplier result valid.
- `mul_result`, input, WIDTH: low WIDTH bits of the product.
- `wr_en`, output, 1: write lane result.
- `wr_lane`, output, 3: destination lane.
- `wr_data`, output, WIDTH: lane result.
- `done`, output, 1: one-cycle pulse, instruction complete.
- `vflags`, output, 2: {any_neg, all_zero} over the written lanes; valid from `done` until the next accept.

## Operation
- States: IDLE, ISSUE, MULWAIT, FINISH.
- IDLE:
  - `ready`=1.
  - On `start`, latch `vl` (values >LANES clamp to LANES) and `alu_ctrl`, clear lane counter, set all_zero=1 and any_neg=0.
  - Go to ISSUE, or to FINISH if latched vl=0.
- ISSUE, non-mul op:
  - `lane_idx`=counter.
  - Compute the result combinationally. Add/sub: result = op_a + (op_b or ~op_b) + ctrl[0], truncated to WIDTH.
  - Register the result, lane and `wr_en` for the next cycle.
  - Increment the counter. After lane vl-1, go to FINISH.
- ISSUE, mul op:
  - Pulse `mul_start` and go to MULWAIT, holding `lane_idx`.
- MULWAIT:
  - `mul_done` is sampled only in this state. On `mul_done`, register `mul_result` for writeback.
  - Increment the counter, then return to ISSUE, or go to FINISH after the last lane.
- Codes 101, 111 (and 110 when mul is compiled out): the lane result is 0. Lanes are still written; no multiplier activity.
- Flag update on every write: all_zero &= (wr_data==0); any_neg |= wr_data[WIDTH-1].
- FINISH: `done`=1 for one cycle, then IDLE.
- `start` while `ready`=0 is ignored and not queued.
- Reset asserted mid-instruction: immediate return to IDLE, no further writes, and any pending `mul_done` is ignored.
- Reset values: `ready`=1; `lane_idx`=0; `mul_start`, `wr_en`, `done` = 0; `wr_lane`, `wr_data` = 0; `vflags`=2'b01.

## Timing
- Accept edge = cycle 0.
- ALU op with vl=N: lane i is read in cycle i+1 and written (`wr_en`) in cycle i+2. `done` is in cycle N+2, coincident with the last write's following cycle. Throughput is one lane per cycle.
- vl=0: `done` in cycle 1, no `wr_en`.
- Mul lane: `mul_start` is in its issue cycle. The write occurs the cycle after `mul_done`, and the next lane issues in that same cycle.
- `ready` returns to 1 in the cycle after `done`.

## Configuration
- `VEC_SEQ_MUL_EN` defined: code 110 uses the mul handshake and MULWAIT exists.
- Undefined: `mul_start` is tied to 0, `mul_done` and `mul_result` are unused, MULWAIT is removed, and 110 produces 0 results at one lane per cycle.

## Structure
- Package `vec_pkg`:
  - ALU control encodings as constants.
  - `VEC_LANES`=5.
  - Sequencer state enum.
- One sub-module, `vec_lane_alu`: a combinational single-lane add/sub/and/or/xor unit with WIDTH parameter, reusable by other vector blocks.

## Test plan
- add, vl=3, op_a=lane+1, op_b=10: writes lanes 0..2 = 11, 12, 13 in cycles 2..4; `done` in cycle 5; vflags=00.
- sub, vl=5, op_a=op_b=7: five writes of 0; vflags=01.
- xor, vl=0: `done` in cycle 1, no `wr_en`; vl=7: exactly five writes, lanes 0..4.
- mul, vl=2, op_a=0x80000000, op_b=2, `mul_done` 3 cycles after each `mul_start` with result 0: two `mul_start` pulses, two writes of 0; vflags=01. Compiled without the macro: no `mul_start`, writes 0 at one lane per cycle.
- `start` pulsed mid-instruction is ignored. Reset driven low during lane 2 of vl=5: no further `wr_en`, `ready`=1 and `vflags`=01 immediately.
- Code 101, vl=2: two writes of 0, and `done` in cycle 4.
